spis_core: RTL and testbench

- SPI target (slave) engine: the responder at the far end of the spim master interface.
- Oversamples SCK/SS_N/MOSI in the system clock domain and deserialises MOSI into bytes. Serialises TX bytes onto MISO.
- Supports all four clock modes and single-line (standard SPI) transfers, MSB first.
- Sits between the pads and a register/FIFO layer that uses byte_fifo instances on the rx and tx sides.

---
 rtl/spis_core.sv | 222 ++++++++++++++++++++++
 tb/tb_spis_core.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spis_core.sv
// spis_core -- SPI target (slave) engine.
//
// Oversamples the asynchronous SPI pins in the clk domain, deserialises MOSI
// into bytes and serialises TX bytes onto MISO, MSB first, in any of the four
// clock modes.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   ckmod[1:0]      {CPOL, CPHA}; latched when a frame starts
//   spi_sck         serial clock from the master (asynchronous)
//   spi_ss_n        target select, active low (asynchronous)
//   spi_mosi        serial data from the master
//   spi_miso        serial data to the master (idles high)
//   spi_miso_oe     MISO output enable, high while a frame is active
//   rx_valid        one-cycle pulse: rx_byte holds a newly completed byte
//   rx_byte[7:0]    last completed received byte
//   tx_valid        tx_byte offered
//   tx_byte[7:0]    next byte to transmit
//   tx_ready        TX holding register empty
//   frame_start     one-cycle pulse on the synchronised SS_N fall
//   frame_end       one-cycle pulse on the synchronised SS_N rise
//   busy            high while a frame is active
//   underrun        one-cycle pulse when IDLE_BYTE replaces missing TX data
module spis_core #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic [7:0]  IDLE_BYTE   = 8'hFF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] ckmod,
   input  logic       spi_sck,
   input  logic       spi_ss_n,
   input  logic       spi_mosi,
   output logic       spi_miso,
   output logic       spi_miso_oe,
   output logic       rx_valid,
   output logic [7:0] rx_byte,
   input  logic       tx_valid,
   input  logic [7:0] tx_byte,
   output logic       tx_ready,
   output logic       frame_start,
   output logic       frame_end,
   output logic       busy,
   output logic       underrun
);

   typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

   // Synchronisers plus one extra registered copy for edge detection.
   // They reset to 0 so that SS_N held low across reset never looks like a
   // falling edge: the master has to deselect and reselect first.
   logic [SYNC_STAGES-1:0] sck_sync_q, ss_sync_q, mosi_sync_q;
   logic                   sck_prev_q, ss_prev_q;

   state_t     state_q, state_d;
   logic [1:0] mode_q, mode_d;
   logic [2:0] cnt_q, cnt_d;
   logic       first_q, first_d;       // no shift edge seen yet in this frame
   logic [7:0] rx_shift_q, rx_shift_d;
   logic [7:0] rx_byte_q, rx_byte_d;
   logic       rx_done_q, rx_done_d;
   logic       rx_valid_q, rx_valid_d;
   logic [7:0] tx_shift_q, tx_shift_d;
   logic [7:0] hold_q, hold_d;
   logic       full_q, full_d;
   logic       oe_q, oe_d;
   logic       fs_q, fs_d;
   logic       fe_q, fe_d;
   logic       ur_q, ur_d;

   logic sck_s, ss_s, mosi_s;
   logic sck_edge, ss_fall, ss_rise;
   logic leading, trailing, sample_edge, shift_edge;
   logic load_evt;

   assign sck_s  = sck_sync_q[SYNC_STAGES-1];
   assign ss_s   = ss_sync_q[SYNC_STAGES-1];
   assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

   assign sck_edge = sck_s ^ sck_prev_q;
   assign ss_fall  = ss_prev_q & ~ss_s;
   assign ss_rise  = ~ss_prev_q & ss_s;

   // Leading edge moves SCK away from its idle level CPOL.
   assign leading     = sck_edge & (sck_s != mode_q[1]);
   assign trailing    = sck_edge & (sck_s == mode_q[1]);
   assign sample_edge = mode_q[0] ? trailing : leading;
   assign shift_edge  = mode_q[0] ? leading  : trailing;

   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      cnt_d      = cnt_q;
      first_d    = first_q;
      rx_shift_d = rx_shift_q;
      rx_byte_d  = rx_byte_q;
      rx_done_d  = 1'b0;
      rx_valid_d = rx_done_q;
      tx_shift_d = tx_shift_q;
      hold_d     = hold_q;
      full_d     = full_q;
      oe_d       = oe_q;
      fs_d       = 1'b0;
      fe_d       = 1'b0;
      ur_d       = 1'b0;
      load_evt   = 1'b0;

      if (tx_valid && !full_q) begin
         hold_d = tx_byte;
         full_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (ss_fall) begin
               state_d  = ACTIVE;
               fs_d     = 1'b1;
               mode_d   = ckmod;
               cnt_d    = 3'd0;
               first_d  = 1'b1;
               oe_d     = 1'b1;
               load_evt = 1'b1;
            end
         end
         ACTIVE: begin
            if (ss_rise) begin
               // Deselect wins over any coincident SCK edge; a partial byte
               // is simply dropped.
               state_d = IDLE;
               fe_d    = 1'b1;
               oe_d    = 1'b0;
               cnt_d   = 3'd0;
            end else if (sample_edge) begin
               rx_shift_d = {rx_shift_q[6:0], mosi_s};
               cnt_d      = cnt_q + 3'd1;
               if (cnt_q == 3'd7) begin
                  rx_byte_d = {rx_shift_q[6:0], mosi_s};
                  rx_done_d = 1'b1;
               end
            end else if (shift_edge) begin
               first_d = 1'b0;
               // A shift edge at count 0 follows a completed byte, except the
               // very first CPHA=1 leading edge, where bit 7 is already out.
               if (cnt_q == 3'd0) begin
                  load_evt = !first_q;
               end else begin
                  tx_shift_d = {tx_shift_q[6:0], 1'b0};
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // A byte accepted in this very cycle is not yet visible to the load.
      if (load_evt) begin
         if (full_q) begin
            tx_shift_d = hold_q;
            full_d     = 1'b0;
         end else begin
            tx_shift_d = IDLE_BYTE;
            ur_d       = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sck_sync_q  <= '0;
         ss_sync_q   <= '0;
         mosi_sync_q <= '0;
         sck_prev_q  <= 1'b0;
         ss_prev_q   <= 1'b0;
         state_q     <= IDLE;
         mode_q      <= 2'b00;
         cnt_q       <= 3'd0;
         first_q     <= 1'b0;
         rx_shift_q  <= 8'h00;
         rx_byte_q   <= 8'h00;
         rx_done_q   <= 1'b0;
         rx_valid_q  <= 1'b0;
         tx_shift_q  <= IDLE_BYTE;
         hold_q      <= 8'h00;
         full_q      <= 1'b0;
         oe_q        <= 1'b0;
         fs_q        <= 1'b0;
         fe_q        <= 1'b0;
         ur_q        <= 1'b0;
      end else begin
         sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
         ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], spi_ss_n};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
         sck_prev_q  <= sck_s;
         ss_prev_q   <= ss_s;
         state_q     <= state_d;
         mode_q      <= mode_d;
         cnt_q       <= cnt_d;
         first_q     <= first_d;
         rx_shift_q  <= rx_shift_d;
         rx_byte_q   <= rx_byte_d;
         rx_done_q   <= rx_done_d;
         rx_valid_q  <= rx_valid_d;
         tx_shift_q  <= tx_shift_d;
         hold_q      <= hold_d;
         full_q      <= full_d;
         oe_q        <= oe_d;
         fs_q        <= fs_d;
         fe_q        <= fe_d;
         ur_q        <= ur_d;
      end
   end

   assign spi_miso    = oe_q ? tx_shift_q[7] : 1'b1;
   assign spi_miso_oe = oe_q;
   assign rx_valid    = rx_valid_q;
   assign rx_byte     = rx_byte_q;
   assign tx_ready    = ~full_q;
   assign frame_start = fs_q;
   assign frame_end   = fe_q;
   assign busy        = (state_q == ACTIVE);
   assign underrun    = ur_q;

endmodule

// File: tb/tb_spis_core.sv
// Bench for spis_core: an SPI master model drives frames; a TX feeder offers
// queued bytes; a monitor collects output pulses.  Expected results come from
// a frame-level model: RX bytes equal the MOSI bytes, and each TX load event
// takes the next supplied byte or IDLE_BYTE with an underrun.
module tb_spis_core;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] ckmod;
   logic       spi_sck, spi_ss_n, spi_mosi;
   logic       spi_miso, spi_miso_oe;
   logic       rx_valid;
   logic [7:0] rx_byte;
   logic       tx_valid;
   logic [7:0] tx_byte;
   logic       tx_ready, frame_start, frame_end, busy, underrun;

   always #5 clk = ~clk;

   spis_core #(.SYNC_STAGES(2), .IDLE_BYTE(8'hFF)) dut (
      .clk(clk), .rst(rst), .ckmod(ckmod),
      .spi_sck(spi_sck), .spi_ss_n(spi_ss_n), .spi_mosi(spi_mosi),
      .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
      .rx_valid(rx_valid), .rx_byte(rx_byte),
      .tx_valid(tx_valid), .tx_byte(tx_byte), .tx_ready(tx_ready),
      .frame_start(frame_start), .frame_end(frame_end),
      .busy(busy), .underrun(underrun)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- TX feeder ----------------
   logic [7:0] tx_src[$];

   initial begin
      logic rdy_snap;
      rdy_snap = 1'b0;
      tx_valid = 1'b0;
      tx_byte  = 8'h00;
      forever begin
         @(negedge clk);
         if (tx_valid && rdy_snap && tx_src.size() > 0) void'(tx_src.pop_front());
         tx_valid = (tx_src.size() > 0);
         tx_byte  = tx_valid ? tx_src[0] : 8'h00;
         rdy_snap = tx_ready && !rst;
      end
   end

   // ---------------- monitor ----------------
   logic [7:0] rx_got[$];
   int   n_fs, n_fe, n_ur, n_rdy_rise;
   logic prev_rdy, fs_miso;

   initial begin
      n_fs = 0; n_fe = 0; n_ur = 0; n_rdy_rise = 0; prev_rdy = 1'b1; fs_miso = 1'b0;
      forever begin
         @(negedge clk);
         if (rx_valid) rx_got.push_back(rx_byte);
         if (frame_start) begin
            n_fs++;
            fs_miso = spi_miso;
         end
         if (frame_end) n_fe++;
         if (underrun) n_ur++;
         if (tx_ready && !prev_rdy) n_rdy_rise++;
         prev_rdy = tx_ready;
      end
   end

   task automatic clear_mon();
      rx_got.delete();
      n_fs = 0; n_fe = 0; n_ur = 0; n_rdy_rise = 0;
      prev_rdy = tx_ready;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tx_src.delete();
      repeat (3) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_miso"},     spi_miso, 1'b1);
      check({tag, "_oe"},       spi_miso_oe, 1'b0);
      check({tag, "_rx_valid"}, rx_valid, 1'b0);
      check({tag, "_rx_byte"},  rx_byte, 8'h00);
      check({tag, "_tx_ready"}, tx_ready, 1'b1);
      check({tag, "_fs"},       frame_start, 1'b0);
      check({tag, "_fe"},       frame_end, 1'b0);
      check({tag, "_busy"},     busy, 1'b0);
      check({tag, "_underrun"}, underrun, 1'b0);
   endtask

   // ---------------- SPI master ----------------
   logic [7:0] mosi_b[8];
   logic [7:0] sup_b[8];
   int         nsup;
   logic       cap_bits[64];
   int         ncap;

   task automatic spi_frame(input logic [1:0] mode, input int nbits, input int hp, input bit keep);
      logic b;
      ncap = 0;
      spi_sck  = mode[1];
      spi_ss_n = 1'b0;
      repeat (hp + 2) @(negedge clk);
      for (int k = 0; k < nbits; k++) begin
         b = mosi_b[k / 8][7 - (k % 8)];
         if (!mode[0]) begin
            spi_mosi = b;
            repeat (hp) @(negedge clk);
            cap_bits[ncap] = spi_miso; ncap++;
            spi_sck = ~mode[1];
            repeat (hp) @(negedge clk);
            spi_sck = mode[1];
         end else begin
            spi_sck  = ~mode[1];
            spi_mosi = b;
            repeat (hp) @(negedge clk);
            cap_bits[ncap] = spi_miso; ncap++;
            spi_sck = mode[1];
            repeat (hp) @(negedge clk);
         end
      end
      repeat (hp + 2) @(negedge clk);
      if (!keep) begin
         spi_ss_n = 1'b1;
         repeat (10) @(negedge clk);
      end
   endtask

   // One frame with the bytes in sup_b[0..nsup-1] queued for TX beforehand.
   task automatic run(input string name, input logic [1:0] mode, input int nbits, input bit do_rst);
      int hp, nb, loads, exp_ur;
      logic [7:0] got, lv;
      hp = $urandom_range(4, 7);
      spi_ss_n = 1'b1;
      spi_sck  = mode[1];
      ckmod    = mode;
      if (do_rst) do_reset();
      repeat (6) @(negedge clk);
      for (int i = 0; i < nsup; i++) tx_src.push_back(sup_b[i]);
      repeat (6) @(negedge clk);
      clear_mon();
      spi_frame(mode, nbits, hp, 1'b0);

      nb = nbits / 8;
      // CPHA=0 has a load on the trailing edge after every completed byte,
      // CPHA=1 on the leading edge of every byte after the first.
      loads  = 1 + (mode[0] ? (nbits - 1) / 8 : nbits / 8);
      exp_ur = (loads > nsup) ? loads - nsup : 0;

      check({name, "_rx_count"}, rx_got.size(), nb);
      for (int j = 0; j < nb; j++)
         if (j < rx_got.size()) check({name, "_rx_byte"}, rx_got[j], mosi_b[j]);
      for (int j = 0; j < nb; j++) begin
         got = 8'h00;
         for (int i = 0; i < 8; i++) got = {got[6:0], cap_bits[8 * j + i]};
         lv = (j < nsup) ? sup_b[j] : 8'hFF;
         check({name, "_miso_byte"}, got, lv);
      end
      check({name, "_underruns"}, n_ur, exp_ur);
      check({name, "_frame_start"}, n_fs, 1);
      check({name, "_frame_end"}, n_fe, 1);
      check({name, "_busy_after"}, busy, 1'b0);
      check({name, "_oe_after"}, spi_miso_oe, 1'b0);
      $display("frame %s mode=%0d bits=%0d hp=%0d rx=%0d underruns=%0d", name, mode, nbits, hp,
               rx_got.size(), n_ur);
   endtask

   initial begin
      int base, nb, loads;
      logic [1:0] m;
      rst = 1'b1; ckmod = 2'b00; spi_sck = 1'b0; spi_ss_n = 1'b1; spi_mosi = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_reset_outputs("reset");

      // Mode 0, TX A5 preloaded, master sends 3C.
      mosi_b[0] = 8'h3C; sup_b[0] = 8'hA5; nsup = 1;
      run("mode0", 2'd0, 8, 1'b1);
      check("mode0_fs_miso_bit7", fs_miso, 1'b1);

      // Mode 3, three bytes, two TX bytes supplied.
      mosi_b[0] = 8'h01; mosi_b[1] = 8'h80; mosi_b[2] = 8'hFF;
      sup_b[0] = 8'h11; sup_b[1] = 8'h22; nsup = 2;
      run("mode3", 2'd3, 24, 1'b1);

      mosi_b[0] = 8'hC3; sup_b[0] = 8'hC3; nsup = 1;
      run("mode1", 2'd1, 8, 1'b1);
      run("mode2", 2'd2, 8, 1'b1);

      // Abort after 5 bits, then a clean byte with no reset in between.
      mosi_b[0] = 8'hE7; nsup = 0;
      run("abort5", 2'd0, 5, 1'b1);
      mosi_b[0] = 8'h5A; nsup = 0;
      run("after_abort", 2'd0, 8, 1'b0);

      // Reset mid-byte with SS_N held low.
      ckmod = 2'd0; spi_sck = 1'b0; do_reset();
      tx_src.push_back(8'h77);
      repeat (6) @(negedge clk);
      mosi_b[0] = 8'hFF;
      spi_frame(2'd0, 4, 5, 1'b1);
      do_reset();
      @(negedge clk);
      check_reset_outputs("midrst");
      clear_mon();
      for (int i = 0; i < 6; i++) begin
         spi_mosi = 1'($urandom_range(0, 1));
         spi_sck  = ~spi_sck;
         repeat (5) @(negedge clk);
      end
      check("midrst_no_fs", n_fs, 0);
      check("midrst_no_fe", n_fe, 0);
      check("midrst_no_rx", rx_got.size(), 0);
      check("midrst_busy", busy, 1'b0);
      mosi_b[0] = 8'h96; nsup = 0;
      run("post_rst", 2'd0, 8, 1'b0);

      // Continuous TX supply over a 4-byte frame.
      m = 2'($urandom_range(0, 3));
      base = $urandom_range(0, 255);
      for (int i = 0; i < 8; i++) sup_b[i] = 8'(base + i);
      for (int i = 0; i < 4; i++) mosi_b[i] = 8'($urandom_range(0, 255));
      nsup = 8;
      run("stream", m, 32, 1'b1);
      loads = 1 + (m[0] ? 3 : 4);
      check("stream_ready_rises", n_rdy_rise, loads);
      check("stream_ready_low_after", tx_ready, 1'b0);

      // Random frames.
      for (int t = 0; t < 6; t++) begin
         m  = 2'($urandom_range(0, 3));
         nb = $urandom_range(1, 3);
         nsup = $urandom_range(0, nb + 1);
         for (int i = 0; i < 8; i++) begin
            mosi_b[i] = 8'($urandom_range(0, 255));
            sup_b[i]  = 8'($urandom_range(0, 255));
         end
         run("random", m, 8 * nb, 1'b1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
